// File: rtl/spi_arb_pkg.sv
// Shared definitions for the SPI transaction arbiter: controller state
// encoding, default sizing and the word returned when a response times out.
package spi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        WAIT_RSP = 2'd2,
        DELIVER  = 2'd3
    } arb_state_t;

    localparam int DEFAULT_DATA_WIDTH     = 32;
    localparam int DEFAULT_TIMEOUT_CYCLES = 4096;

    // All-ones error word; sliced down to DATA_WIDTH (up to 64 bits) at use.
    localparam logic [63:0] ERR_WORD = '1;

    // Index width for a vector of n entries, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_arbiter_rr_picker.sv
// Round-robin search: returns the first asserted request at or above ptr,
// wrapping past the top index back to zero.
module rr_picker
    import spi_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    logic [2*N_REQ-1:0] req_twice;
    logic [N_REQ-1:0]   req_rot;

    // Rotate the request vector so bit j of req_rot is requester (ptr+j) mod N_REQ.
    always_comb begin
        req_twice = {req, req};
        req_rot   = N_REQ'(req_twice >> ptr);
    end

    // Scan from the highest offset down so the smallest offset from ptr wins.
    always_comb begin
        any = |req;
        idx = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (req_rot[j]) begin
                idx = IDX_W'((int'(ptr) + j) % N_REQ);
            end
        end
    end

endmodule

// File: rtl/spi_arbiter.sv
// Arbitrates N_REQ requesters onto one SPI command/response channel. One
// transaction is in flight at a time: accept a command, forward it to the
// SPI master, wait (with timeout) for the reply, then hand the reply back to
// the requester that issued it. Grants rotate round-robin after each reply.
module spi_arbiter
    import spi_arb_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    localparam int IDX_W         = idx_width(N_REQ),
    localparam int CNT_W         = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data_i,
    input  logic [N_REQ-1:0]            req_valid_i,
    output logic [N_REQ-1:0]            req_ready_o,
    output logic [DATA_WIDTH-1:0]       rsp_data_o,
    output logic [N_REQ-1:0]            rsp_valid_o,
    output logic                        rsp_err_o,
    input  logic [N_REQ-1:0]            rsp_ready_i,
    output logic [DATA_WIDTH-1:0]       sdo_data_o,
    output logic                        sdo_valid_o,
    input  logic                        sdo_ready_i,
    input  logic [DATA_WIDTH-1:0]       sdi_data_i,
    input  logic                        sdi_valid_i,
    output logic                        sdi_ready_o,
    output logic [IDX_W-1:0]            grant_o,
    output logic                        busy_o
);

    arb_state_t       state;
    logic [IDX_W-1:0] ptr;
    logic [CNT_W-1:0] wait_cnt;
    logic             pick_any;
    logic [IDX_W-1:0] pick_idx;

    rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req (req_valid_i),
        .ptr (ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    // Outputs that follow directly from the current state.
    assign sdo_valid_o = (state == SEND);
    assign sdi_ready_o = (state == WAIT_RSP);
    assign busy_o      = (state != IDLE);

    // Accept strobe goes to the round-robin winner only while idle and out of reset.
    always_comb begin
        req_ready_o = '0;
        if (!rst && state == IDLE && pick_any) begin
            req_ready_o[pick_idx] = 1'b1;
        end
    end

    // Response valid is steered to the granted requester while delivering.
    always_comb begin
        rsp_valid_o = '0;
        if (state == DELIVER) begin
            rsp_valid_o[grant_o] = 1'b1;
        end
    end

    // Transaction controller: accept, send, wait with timeout, deliver.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            grant_o    <= '0;
            wait_cnt   <= '0;
            sdo_data_o <= '0;
            rsp_data_o <= '0;
            rsp_err_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant_o    <= pick_idx;
                        sdo_data_o <= req_data_i[pick_idx*DATA_WIDTH +: DATA_WIDTH];
                        state      <= SEND;
                    end
                end
                SEND: begin
                    if (sdo_ready_i) begin
                        wait_cnt <= '0;
                        state    <= WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    if (sdi_valid_i) begin
                        rsp_data_o <= sdi_data_i;
                        rsp_err_o  <= 1'b0;
                        state      <= DELIVER;
                    end else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        rsp_data_o <= DATA_WIDTH'(ERR_WORD);
                        rsp_err_o  <= 1'b1;
                        state      <= DELIVER;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                DELIVER: begin
                    if (rsp_ready_i[grant_o]) begin
                        ptr   <= (grant_o == IDX_W'(N_REQ - 1)) ? '0 : grant_o + IDX_W'(1);
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
